// File: rtl/card_dealer.sv
// Card dealer: draws ranks 1..13 from an external random source, rejecting
// exhausted ranks, and falls back to an ascending scan after repeated rejections.
module card_dealer #(
  parameter int MAX_COPIES = 4,
  parameter int RETRY_MAX  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rnd,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic       deal_err,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic [1:0] o_dbg_state
);

  localparam int          RW        = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
  localparam logic [2:0]  MAXC      = 3'(MAX_COPIES);
  localparam logic [5:0]  DECK_SIZE = 6'(13 * MAX_COPIES);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX - 1);

  // Handshake: deal_req is a level sampled only while idle (busy=0); each
  // accepted request yields exactly one card_valid pulse or one deal_err pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SCAN  = 2'd2,
    DEAL  = 2'd3
  } state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_used [13];
  logic [5:0]      r_cards_left;
  logic [3:0]      r_cand;
  logic [3:0]      r_scan_idx;
  logic [3:0]      r_taken;
  logic [RW-1:0]   r_retry;
  logic            r_card_valid;
  logic [3:0]      r_card_value;
  logic            r_deal_err;

  logic [15:0]     w_avail;
  logic            w_cand_ok;
  logic            w_scan_ok;
  logic            w_start;
  logic            w_retry_inc;
  logic            w_scan_start;
  logic            w_scan_inc;
  logic            w_take;
  logic [3:0]      w_take_rank;
  logic            w_fire;
  logic            w_err;

  // Indexed by rank; invalid ranks 0, 14 and 15 are never available.
  always_comb begin
    w_avail = '0;
    for (int r = 1; r <= 13; r++) begin
      w_avail[r] = (r_used[r-1] < MAXC);
    end
  end

  assign w_cand_ok = w_avail[r_cand];
  assign w_scan_ok = w_avail[r_scan_idx];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_retry_inc  = 1'b0;
    w_scan_start = 1'b0;
    w_scan_inc   = 1'b0;
    w_take       = 1'b0;
    w_take_rank  = '0;
    w_fire       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (deal_req) begin
          if (r_cards_left == '0) begin
            w_err = 1'b1;
          end else begin
            w_start = 1'b1;
            w_next  = CHECK;
          end
        end
      end
      CHECK: begin
        if (w_cand_ok) begin
          w_take      = 1'b1;
          w_take_rank = r_cand;
          w_next      = DEAL;
        end else if (r_retry == RETRY_LAST) begin
          w_scan_start = 1'b1;
          w_next       = SCAN;
        end else begin
          w_retry_inc = 1'b1;
        end
      end
      SCAN: begin
        if (w_scan_ok) begin
          w_take      = 1'b1;
          w_take_rank = r_scan_idx;
          w_next      = DEAL;
        end else begin
          w_scan_inc = 1'b1;
        end
      end
      DEAL: begin
        w_fire = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Shuffle aborts whatever is in flight, including a pending card_valid.
    if (shuffle) begin
      w_next       = IDLE;
      w_start      = 1'b0;
      w_retry_inc  = 1'b0;
      w_scan_start = 1'b0;
      w_scan_inc   = 1'b0;
      w_take       = 1'b0;
      w_fire       = 1'b0;
      w_err        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 13; i++) r_used[i] <= '0;
      r_cards_left <= DECK_SIZE;
      r_cand       <= '0;
      r_scan_idx   <= '0;
      r_taken      <= '0;
      r_retry      <= '0;
      r_card_valid <= 1'b0;
      r_card_value <= '0;
      r_deal_err   <= 1'b0;
    end else begin
      r_card_valid <= w_fire;
      r_deal_err   <= w_err;
      if (shuffle) begin
        for (int i = 0; i < 13; i++) r_used[i] <= '0;
        r_cards_left <= DECK_SIZE;
      end else begin
        if (w_start) begin
          r_cand  <= rnd;
          r_retry <= '0;
        end
        if (w_retry_inc) begin
          r_cand  <= rnd;
          r_retry <= r_retry + 1'b1;
        end
        if (w_scan_start) r_scan_idx <= 4'd1;
        if (w_scan_inc)   r_scan_idx <= r_scan_idx + 4'd1;
        if (w_take) begin
          for (int i = 0; i < 13; i++) begin
            if (w_take_rank == 4'(i + 1)) r_used[i] <= r_used[i] + 3'd1;
          end
          r_cards_left <= r_cards_left - 6'd1;
          r_taken      <= w_take_rank;
        end
        if (w_fire) r_card_value <= r_taken;
      end
    end
  end

  assign card_valid  = r_card_valid;
  assign card_value  = r_card_value;
  assign deal_err    = r_deal_err;
  assign busy        = (r_state != IDLE);
  assign cards_left  = r_cards_left;
  assign deck_empty  = (r_cards_left == '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: latency, rejection/scan fallback, deck
// exhaustion, shuffle/reset aborts and request handling while busy.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rnd;
  logic       deal_req;
  logic       shuffle;
  logic       card_valid;
  logic [3:0] card_value;
  logic       deal_err;
  logic       busy;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  card_dealer #(.MAX_COPIES(4), .RETRY_MAX(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rnd         (rnd),
    .deal_req    (deal_req),
    .shuffle     (shuffle),
    .card_valid  (card_valid),
    .card_value  (card_value),
    .deal_err    (deal_err),
    .busy        (busy),
    .cards_left  (cards_left),
    .deck_empty  (deck_empty),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse deal_req for one edge, then wait (bounded) for card_valid.
  // lat counts edges after the edge that sampled deal_req.
  task automatic do_deal(output logic ok, output logic [3:0] val, output int lat,
                         output logic saw_err);
    ok = 1'b0; val = '0; lat = 0; saw_err = 1'b0;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    saw_err = deal_err;
    while (lat < 40) begin
      tick();
      lat++;
      saw_err = saw_err | deal_err;
      if (card_valid) begin
        ok  = 1'b1;
        val = card_value;
        break;
      end
    end
  endtask

  task automatic do_shuffle();
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (card_valid) cnt++;
    end
  endtask

  logic       ok, err;
  logic [3:0] val;
  int         lat, nv, waited;
  int         rank_cnt [16];

  initial begin
    rst = 1'b1; rnd = 4'd5; deal_req = 1'b0; shuffle = 1'b1;
    tick(); tick();
    rst = 1'b0; shuffle = 1'b0;
    check("rst_card_valid", card_valid, 0);
    check("rst_card_value", card_value, 0);
    check("rst_deal_err",   deal_err, 0);
    check("rst_busy",       busy, 0);
    check("rst_cards_left", cards_left, 52);
    check("rst_deck_empty", deck_empty, 0);
    check("rst_state",      dbg_state, 0);

    // First-sample accept, cycle by cycle.
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    check("lat_e0_busy",  busy, 1);
    check("lat_e0_state", dbg_state, 1);
    check("lat_e0_valid", card_valid, 0);
    tick();
    check("lat_e1_state", dbg_state, 3);
    check("lat_e1_valid", card_valid, 0);
    tick();
    check("lat_e2_valid", card_valid, 1);
    check("lat_e2_value", card_value, 5);
    check("lat_e2_busy",  busy, 0);
    check("lat_left",     cards_left, 51);
    tick();
    check("lat_e3_valid", card_valid, 0);
    check("lat_e3_value_held", card_value, 5);

    // Rank 7 exhausted after four deals; fifth falls back to the scan.
    do_shuffle();
    check("shuf_left", cards_left, 52);
    rnd = 4'd7;
    for (int k = 0; k < 4; k++) begin
      do_deal(ok, val, lat, err);
      check("r7_ok", ok, 1);
      check("r7_value", val, 7);
      check("r7_lat", 8'(lat), 2);
    end
    do_deal(ok, val, lat, err);
    check("r7_scan_ok", ok, 1);
    check("r7_scan_value", val, 1);
    check("r7_scan_lat", 8'(lat), 10);
    check("r7_left", cards_left, 47);

    // Invalid ranks always go to the scan.
    do_shuffle();
    rnd = 4'd0;
    do_deal(ok, val, lat, err);
    check("rnd0_value", val, 1);
    check("rnd0_lat", 8'(lat), 10);
    check("rnd0_err", err, 0);
    rnd = 4'd14;
    do_deal(ok, val, lat, err);
    check("rnd14_value", val, 1);
    check("rnd14_err", err, 0);
    check("rnd14_left", cards_left, 50);

    // Full deck with random samples.
    do_shuffle();
    for (int r = 0; r < 16; r++) rank_cnt[r] = 0;
    for (int k = 0; k < 52; k++) begin
      rnd = 4'($urandom_range(0, 15));
      do_deal(ok, val, lat, err);
      check("full_ok", ok, 1);
      if (ok) rank_cnt[val]++;
    end
    for (int r = 1; r <= 13; r++) check("full_rank_cnt", 8'(rank_cnt[r]), 4);
    check("full_bad_rank0", 8'(rank_cnt[0]), 0);
    check("full_left", cards_left, 0);
    check("full_empty", deck_empty, 1);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    check("empty_err", deal_err, 1);
    check("empty_busy", busy, 0);
    check("empty_valid", card_valid, 0);
    tick();
    check("empty_err_pulse", deal_err, 0);
    count_valid(5, nv);
    check("empty_no_valid", 8'(nv), 0);
    do_shuffle();
    check("refill_left", cards_left, 52);
    check("refill_empty", deck_empty, 0);

    // Shuffle while in CHECK.
    rnd = 4'd5;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    check("abort_chk_state", dbg_state, 1);
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    check("abort_chk_idle", dbg_state, 0);
    check("abort_chk_valid", card_valid, 0);
    check("abort_chk_left", cards_left, 52);
    count_valid(5, nv);
    check("abort_chk_novalid", 8'(nv), 0);

    // Shuffle while in SCAN.
    rnd = 4'd0;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    waited = 0;
    while (dbg_state != 2'd2 && waited < 20) begin
      tick();
      waited++;
    end
    check("abort_scan_reached", dbg_state, 2);
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    check("abort_scan_idle", dbg_state, 0);
    check("abort_scan_valid", card_valid, 0);
    check("abort_scan_left", cards_left, 52);
    count_valid(5, nv);
    check("abort_scan_novalid", 8'(nv), 0);

    // Reset in DEAL suppresses the card.
    rnd = 4'd9;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    tick();
    check("rst_mid_deal_state", dbg_state, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", card_valid, 0);
    check("rst_mid_left", cards_left, 52);
    check("rst_mid_value", card_value, 0);
    count_valid(4, nv);
    check("rst_mid_novalid", 8'(nv), 0);

    // deal_req held high across the busy window: one card only.
    rnd = 4'd3;
    deal_req = 1'b1;
    tick(); tick(); tick();
    deal_req = 1'b0;
    nv = card_valid ? 1 : 0;
    check("held_value", card_value, 3);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (card_valid) nv++;
    end
    check("held_one_valid", 8'(nv), 1);
    check("held_left", cards_left, 51);

    // Shuffle wins over a simultaneous deal_req.
    deal_req = 1'b1;
    shuffle  = 1'b1;
    tick();
    deal_req = 1'b0;
    shuffle  = 1'b0;
    check("both_idle", dbg_state, 0);
    check("both_left", cards_left, 52);
    count_valid(5, nv);
    check("both_novalid", 8'(nv), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter MAX_COPIES, default 4, SHALL set the copies of each rank in a full deck (deck size = 13*MAX_COPIES = 52).
REQ-002 Parameter RETRY_MAX, default 8, SHALL set the consecutive random-sample rejections before the fallback scan.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rnd  input  4  rank from the random generator; valid ranks 1..13; 0, 14 and 15 are invalid; may change every cycle.
REQ-006 deal_req  input  1  request one card; sampled only in IDLE.
REQ-007 shuffle  input  1  refill the deck to full; sampled in every state.
REQ-008 card_valid  output  1  registered; one-cycle pulse marking a dealt card.
REQ-009 card_value  output  4  registered; rank of the last dealt card, held between deals.
REQ-010 deal_err  output  1  registered; one-cycle pulse when deal_req arrives with the deck empty.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 cards_left  output  6  cards remaining in the deck.
REQ-013 deck_empty  output  1  high when cards_left == 0.

Function
REQ-014 The block SHALL keep 13 per-rank used counters (3 bits each); a rank is available when its counter < MAX_COPIES.
REQ-015 The FSM SHALL have exactly the states IDLE, CHECK, SCAN and DEAL.
REQ-016 IDLE: on deal_req=1 with deck_empty=0, the block SHALL capture rnd into candidate, clear retry_cnt and enter CHECK.
REQ-017 IDLE: on deal_req=1 with deck_empty=1, the block SHALL pulse deal_err for one cycle and stay in IDLE.
REQ-018 CHECK, accept: if candidate is in 1..13 and available, the block SHALL increment that rank's counter, decrement cards_left and enter DEAL.
REQ-019 CHECK, reject with retry_cnt < RETRY_MAX-1: the block SHALL increment retry_cnt, recapture the current rnd into candidate and stay in CHECK.
REQ-020 CHECK, reject with retry_cnt == RETRY_MAX-1: the block SHALL set scan_idx=1 and enter SCAN.
REQ-021 SCAN SHALL test one rank per cycle, starting at 1 and ascending; the first available rank SHALL be taken as in REQ-018 and the FSM SHALL enter DEAL.
REQ-022 SCAN cannot run past 13, because deck_empty=0 is guaranteed on entry.
REQ-023 DEAL SHALL drive card_valid=1 for exactly one cycle, with card_value equal to the taken rank, then return to IDLE.
REQ-024 On a first-sample accept, card_valid SHALL be high in the cycle following the second rising edge after the edge that sampled deal_req (latency 2).
REQ-025 deal_req SHALL be ignored while busy=1; requests are not queued.
REQ-026 shuffle=1 SHALL, at the next edge and from any state, do all of the following: clear every counter, set cards_left=52, abort any in-flight deal with no card_valid, and enter IDLE.
REQ-027 When shuffle and deal_req are high in the same cycle, shuffle SHALL win and deal_req SHALL be dropped.
REQ-028 cards_left SHALL never underflow or exceed 52; the sum of the per-rank counters plus cards_left SHALL always equal 52.

Reset
REQ-029 rst=1 SHALL, at the next edge, set the state to IDLE, clear all counters, retry_cnt and scan_idx, set cards_left=52, card_valid=0, card_value=0 and deal_err=0.
REQ-030 rst SHALL take priority over shuffle and deal_req, and a reset mid-deal SHALL produce no card_valid.

Verification
REQ-031 After reset, rnd held at 5, one deal_req pulse -> card_valid pulse at latency 2 with card_value=5; cards_left=51.
REQ-032 rnd held at 7, five separate deals -> first four give 7; the fifth rejects RETRY_MAX samples, scans and gives 1; cards_left=47.
REQ-033 rnd held at 0 (then at 14) -> scan path deals rank 1; deal_err stays 0.
REQ-034 52 deals with random rnd -> every rank dealt exactly 4 times and deck_empty=1; a 53rd deal_req -> deal_err pulse and no card_valid; shuffle -> cards_left=52, deck_empty=0.
REQ-035 shuffle asserted while in CHECK or SCAN -> no card_valid, IDLE on the next cycle, cards_left=52.
REQ-036 deal_req repeated while busy=1 -> exactly one card_valid per accepted request; deal_req and shuffle in the same cycle -> no deal.
